// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//   Shared constants and helpers for the multi-channel clock divider.
//   Holds the legal parameter ranges and the ceil(D/2) helper that sets the
//   low/high split of every divided clock. Nothing here depends on instance
//   parameters, so every channel width can share the same definitions.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int unsigned DIV_W_MIN    = 2;
  localparam int unsigned DIV_W_MAX    = 32;
  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 16;

  // Number of low cycles in a period of length d: ceil(d/2).
  // Computed as (d >> 1) + d[0] so it cannot overflow even at d = 2^32-1.
  function automatic logic [DIV_W_MAX-1:0] ceil_half(input logic [DIV_W_MAX-1:0] d);
    return (d >> 1) + {{(DIV_W_MAX-1){1'b0}}, d[0]};
  endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
//   One divider channel. Holds an active divisor, a shadow divisor written by
//   div_we_i, and a period counter. The shadow is promoted to active only at a
//   period boundary (natural wrap, sync, or whenever the channel is idle), so a
//   running period is never cut short by a divisor write.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : run enable
//   div_i        : new divisor value, captured when div_we_i is high
//   div_we_i     : one-cycle divisor write strobe
//   sync_i       : phase-realign strobe (restart the period next cycle)
//   clk_out_o    : divided clock, low for ceil(D/2) cycles then high
//   tick_o       : high in the first cycle of every period
//   pend_o       : a written divisor is waiting for the next boundary
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned RESET_DIV = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_we_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [DIV_W-1:0] RESET_DIV_W = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q,    cnt_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             run_q,    run_d;
  logic             pend_q,   pend_d;
  logic             tick_q,   tick_d;
  logic             clk_out_q, clk_out_d;

  logic last_cnt;   // current cycle is the final one of a running period
  logic boundary;   // shadow divisor may be promoted on this edge
  logic restart;    // counter returns to 0 on this edge

  // NOTE: every signal assigned in this block gets a value on every path, so
  // no latch can be inferred; keep it that way when adding terms.
  always_comb begin
    // run_q guarantees div_q != 0, so div_q - 1 never wraps when it matters.
    last_cnt = run_q && (cnt_q == div_q - ONE);

    // An idle channel (disabled now, or not running last cycle, which also
    // covers D == 0) is always at a boundary, so writes land immediately.
    boundary = !en_i || !run_q || sync_i || last_cnt;

    shadow_d = div_we_i ? div_i : shadow_q;
    div_d    = boundary ? shadow_d : div_q;
    pend_d   = boundary ? 1'b0 : (pend_q || div_we_i);

    run_d    = en_i && (div_d != '0);

    // A wrap and a sync on the same edge both just mean "restart", so they
    // yield one tick together rather than two.
    restart  = !run_q || sync_i || last_cnt;

    if (!run_d) begin
      cnt_d = '0;
    end else if (restart) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    // Outputs are computed from next-state values and registered below, so
    // no input reaches clk_out_o or tick_o without passing through a flop.
    tick_d    = run_d && (cnt_d == '0);
    clk_out_d = run_d && (32'(cnt_d) >= ceil_half(32'(div_d)));
  end

  // NOTE: state registers use non-blocking assignments only; the asynchronous
  // reset clears outputs at once, so a reset mid-period cannot emit a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= RESET_DIV_W;
      shadow_q  <= RESET_DIV_W;
      run_q     <= 1'b0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      run_q     <= run_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule : clk_div_chan

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   CHANNELS independent programmable clock dividers sharing one clock and a
//   global sync strobe that restarts the period of every running channel.
//
// Parameters
//   CHANNELS  : number of channels, 1..16
//   DIV_W     : divisor / counter width, 2..32
//   RESET_DIV : divisor active in every channel after reset
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : per-channel run enable
//   div_in     : per-channel divisor, channel c in bits [c*DIV_W +: DIV_W]
//   div_we     : per-channel divisor write strobe
//   sync       : global phase-realign strobe
//   clk_out    : per-channel divided clock (registered)
//   tick       : per-channel period-start pulse (registered)
//   pend       : per-channel "written divisor not yet active"
// -----------------------------------------------------------------------------
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned RESET_DIV = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*DIV_W-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_we,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pend
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    clk_div_chan #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en[c]),
      .div_i     (div_in[c*DIV_W +: DIV_W]),
      .div_we_i  (div_we[c]),
      .sync_i    (sync),
      .clk_out_o (clk_out[c]),
      .tick_o    (tick[c]),
      .pend_o    (pend[c])
    );
  end

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//   Self-checking bench for clk_div_multi. Directed scenarios compare against
//   hand-derived waveforms; a randomized phase compares against a behavioural
//   model that tracks each channel as "position within the current period".
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

  localparam int CH = 2;
  localparam int W  = 16;
  localparam int RD = 26;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CH-1:0] en     = '0;
  logic [CH-1:0] div_we = '0;
  logic [CH*W-1:0] div_in = '0;
  logic          sync   = 1'b0;
  logic [CH-1:0] clk_out, tick, pend;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .CHANNELS  (CH),
    .DIV_W     (W),
    .RESET_DIV (RD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_in  (div_in),
    .div_we  (div_we),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int d;        // active divisor
    int shadow;   // most recently written divisor
    bit pend;
    bit run;      // channel produced a period position this cycle
    int pos;      // position within the current period
  } ch_t;

  ch_t m [CH];

  function automatic ch_t next_ch(ch_t s, bit e, int din, bit we, bit sy);
    ch_t n;
    int  adv;
    bit  new_period;
    n = s;
    adv = s.run ? (s.pos + 1) % s.d : 0;
    new_period = !s.run || sy || (adv == 0);
    if (we) begin
      n.shadow = din;
      n.pend   = 1'b1;
    end
    if (!e || new_period) begin
      n.d    = n.shadow;
      n.pend = 1'b0;
    end
    n.run = e && (n.d > 0);
    n.pos = (n.run && !new_period) ? adv : 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) m[c] <= '{d: RD, shadow: RD, pend: 1'b0, run: 1'b0, pos: 0};
    end else begin
      for (int c = 0; c < CH; c++)
        m[c] <= next_ch(m[c], en[c], int'(div_in[c*W +: W]), div_we[c], sync);
    end
  end

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m[c].run && (m[c].pos == 0);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_clk();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m[c].run && (m[c].pos >= (m[c].d + 1) / 2);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_pend();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m[c].pend;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Writes a divisor for one cycle; returns at the falling edge after the write.
  task automatic set_div(input int c, input int v);
    div_in[c*W +: W] = W'(v);
    div_we[c] = 1'b1;
    step();
    div_we[c] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    en    = '1;
    repeat (2) step();
    tests_run++;
    if (tick !== '0 || clk_out !== '0 || pend !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: tick=%b clk_out=%b pend=%b expected all 0", tick, clk_out, pend);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (tick !== '1) begin
      tests_failed++;
      $display("FAIL reset_first_tick: tick=%b expected 11", tick);
    end
    for (int k = 1; k <= RD; k++) begin
      step();
      tests_run++;
      if (tick !== {CH{k == RD}}) begin
        tests_failed++;
        $display("FAIL reset_period k=%0d: tick=%b expected %b", k, tick, {CH{k == RD}});
      end
      if (k == 12 || k == 13) begin
        tests_run++;
        if (clk_out !== {CH{k == 13}}) begin
          tests_failed++;
          $display("FAIL reset_clk_edge k=%0d: clk_out=%b expected %b", k, clk_out, {CH{k == 13}});
        end
      end
    end
    en = '0;
    step();
  endtask

  task automatic test_div4();
    set_div(0, 4);
    tests_run++;
    if (pend[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL div4_idle_write_pend: pend=%b expected 0", pend[0]);
    end
    en[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      tests_run++;
      if ({tick[0], clk_out[0]} !== {k % 4 == 0, k % 4 >= 2}) begin
        tests_failed++;
        $display("FAIL div4 k=%0d: tick,clk=%b%b expected %b%b", k, tick[0], clk_out[0], k % 4 == 0, k % 4 >= 2);
      end
    end
  endtask

  task automatic test_div5_div1();
    en[0] = 1'b0;
    set_div(0, 5);
    en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      tests_run++;
      if ({tick[0], clk_out[0]} !== {k % 5 == 0, k % 5 >= 3}) begin
        tests_failed++;
        $display("FAIL div5 k=%0d: tick,clk=%b%b expected %b%b", k, tick[0], clk_out[0], k % 5 == 0, k % 5 >= 3);
      end
    end
    en[0] = 1'b0;
    set_div(0, 1);
    en[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if ({tick[0], clk_out[0]} !== 2'b10) begin
        tests_failed++;
        $display("FAIL div1 k=%0d: tick,clk=%b%b expected 10", k, tick[0], clk_out[0]);
      end
    end
  endtask

  task automatic test_retarget();
    int exp_t [12] = '{1,0,0,0,0,0,1,0,0,1,0,0};
    int exp_c [12] = '{0,0,0,1,1,1,0,0,1,0,0,1};
    int exp_p [12] = '{0,0,0,1,1,1,0,0,0,0,0,0};
    en[0] = 1'b0;
    set_div(0, 6);
    en[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      tests_run++;
      if ({tick[0], clk_out[0], pend[0]} !== {exp_t[k][0], exp_c[k][0], exp_p[k][0]}) begin
        tests_failed++;
        $display("FAIL retarget k=%0d: tick,clk,pend=%b%b%b expected %0d%0d%0d",
                 k, tick[0], clk_out[0], pend[0], exp_t[k], exp_c[k], exp_p[k]);
      end
      if (k == 2) begin
        div_in[0 +: W] = W'(3);
        div_we[0] = 1'b1;
      end else begin
        div_we[0] = 1'b0;
      end
    end
  endtask

  task automatic test_sync();
    en = '0;
    div_in = {16'd6, 16'd4};
    div_we = '1;
    step();
    div_we = '0;
    en[0] = 1'b1;
    repeat (2) step();
    en[1] = 1'b1;
    repeat (3) step();
    sync = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      sync = 1'b0;
      tests_run++;
      if (tick !== {k % 6 == 0, k % 4 == 0}) begin
        tests_failed++;
        $display("FAIL sync_align k=%0d: tick=%b expected %b", k, tick, {k % 6 == 0, k % 4 == 0});
      end
    end
    // Both channels are on their last period cycle here: sync meets the wrap.
    sync = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      sync = 1'b0;
      tests_run++;
      if (tick !== {j % 6 == 0, j % 4 == 0}) begin
        tests_failed++;
        $display("FAIL sync_on_wrap j=%0d: tick=%b expected %b", j, tick, {j % 6 == 0, j % 4 == 0});
      end
    end
  endtask

  task automatic test_reset_midperiod();
    en = '0;
    div_in = {16'd2, 16'd8};
    div_we = '1;
    step();
    div_we = '0;
    en = '1;
    repeat (4) step();
    tests_run++;
    if (clk_out[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: clk_out[1]=%b expected 1", clk_out[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (tick !== '0 || clk_out !== '0 || pend !== '0) begin
      tests_failed++;
      $display("FAIL midreset_drop: tick=%b clk_out=%b pend=%b expected all 0", tick, clk_out, pend);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (tick !== '0 || clk_out !== '0) begin
        tests_failed++;
        $display("FAIL midreset_hold k=%0d: tick=%b clk_out=%b expected 0", k, tick, clk_out);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k <= RD; k++) begin
      step();
      tests_run++;
      if (tick !== {CH{k == 0 || k == RD}}) begin
        tests_failed++;
        $display("FAIL midreset_period k=%0d: tick=%b expected %b", k, tick, {CH{k == 0 || k == RD}});
      end
    end
  endtask

  task automatic test_enable_gap();
    en = '0;
    set_div(0, 4);
    en[0] = 1'b1;
    repeat (6) step();
    en[0] = 1'b0;
    for (int g = 0; g < 5; g++) begin
      step();
      tests_run++;
      if ({tick[0], clk_out[0]} !== 2'b00) begin
        tests_failed++;
        $display("FAIL gap_quiet g=%0d: tick,clk=%b%b expected 00", g, tick[0], clk_out[0]);
      end
      if (g == 1) begin
        div_in[0 +: W] = W'(10);
        div_we[0] = 1'b1;
      end
      if (g == 2) begin
        div_we[0] = 1'b0;
        tests_run++;
        if (pend[0] !== 1'b0) begin
          tests_failed++;
          $display("FAIL gap_pend: pend=%b expected 0", pend[0]);
        end
      end
    end
    en[0] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      tests_run++;
      if ({tick[0], clk_out[0]} !== {k % 10 == 0, k % 10 >= 5}) begin
        tests_failed++;
        $display("FAIL gap_div10 k=%0d: tick,clk=%b%b expected %b%b", k, tick[0], clk_out[0], k % 10 == 0, k % 10 >= 5);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      step();
      tests_run++;
      if (tick !== exp_tick() || clk_out !== exp_clk() || pend !== exp_pend()) begin
        tests_failed++;
        $display("FAIL random i=%0d: tick=%b clk=%b pend=%b expected %b %b %b",
                 i, tick, clk_out, pend, exp_tick(), exp_clk(), exp_pend());
      end
      for (int c = 0; c < CH; c++) begin
        en[c]     = ($urandom_range(0, 15) != 0);
        div_we[c] = ($urandom_range(0, 9) == 0);
        r = int'($urandom_range(0, 19));
        if (r == 0)      div_in[c*W +: W] = '0;
        else if (r == 1) div_in[c*W +: W] = W'(1);
        else if (r == 2) div_in[c*W +: W] = '1;
        else             div_in[c*W +: W] = W'($urandom_range(2, 12));
      end
      sync = ($urandom_range(0, 29) == 0);
    end
    en = '0; div_we = '0; sync = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div5_div1();
    test_retarget();
    test_sync();
    test_reset_midperiod();
    test_enable_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_clk_div_multi
